fifo_uart_tx: RTL

//  Downstream drain stage for sync_fifo: pops bytes when the FIFO is non-empty and serialises each as an
//  8N1 UART frame on tx. Sits between the byte FIFO and the board TX pin; the FIFO absorbs bursts while

---
 rtl/fifo_uart_pkg.sv | 25 ++
 rtl/fifo_uart_tx_if.sv | 24 ++
 rtl/sync_fifo.sv | 52 +++++
 rtl/uart_bit_timer.sv | 24 ++
 rtl/fifo_uart_tx.sv | 139 +++++++++++++
 5 files changed

// File: rtl/fifo_uart_pkg.sv
// Shared types and helpers for the FIFO-fed UART transmitter.
// No logic of its own; no latency.
// No handshake; consumed by fifo_uart_tx and its bench.
package fifo_uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    LOAD,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  // Level of the serial line between frames.
  localparam logic TX_IDLE_LVL = 1'b1;

  // Even parity over up to 32 data bits; narrower bytes are zero-extended,
  // which leaves the XOR unchanged.
  function automatic logic calc_parity(input logic [31:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/fifo_uart_tx_if.sv
// Read-side handshake between a byte FIFO and the UART drain stage.
// Pure wiring; no latency.
// master pulses fifo_rd_en only while fifo_empty is low; data follows one cycle later.
interface fifo_uart_tx_if #(
  parameter int DATA_W = 8
);
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_data;
  logic              fifo_rd_en;

  // Drain side: issues pops, receives status and data.
  modport master (
    input  fifo_empty,
    input  fifo_data,
    output fifo_rd_en
  );

  // FIFO side: accepts pops, supplies status and data.
  modport slave (
    output fifo_empty,
    output fifo_data,
    input  fifo_rd_en
  );
endinterface

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO; DEPTH must be a power of two.
// Registered read data: data_out is valid the cycle after a read_en cycle.
// Writes while full and reads while empty are ignored; no internal stall.
module sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              write_en,
  input  logic [DATA_W-1:0] data_in,
  input  logic              read_en,
  output logic [DATA_W-1:0] data_out,
  output logic              empty,
  output logic              full
);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic              do_wr;
  logic              do_rd;

  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));
  assign do_wr = write_en && !full;
  assign do_rd = read_en && !empty;

  // Storage array; no reset needed since reads are gated by count.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= data_in;
  end

  // Pointers, occupancy and the registered read port.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      data_out <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) begin
        rd_ptr   <= rd_ptr + 1'b1;
        data_out <= mem[rd_ptr];
      end
      if (do_wr && !do_rd)      count <= count + 1'b1;
      else if (do_rd && !do_wr) count <= count - 1'b1;
    end
  end
endmodule

// File: rtl/uart_bit_timer.sv
// Bit-period counter shared by the UART TX and RX sides.
// bit_end is high on the last of every CLKS_PER_BIT cycles after clr drops.
// No handshake; clr holds the count at zero.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 868,
  localparam int CW          = $clog2(CLKS_PER_BIT)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  output logic          bit_end,
  output logic [CW-1:0] cnt
);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  assign bit_end = (cnt == LAST);

  // Count 0..CLKS_PER_BIT-1 and wrap on each bit boundary.
  always_ff @(posedge clk) begin
    if (reset || clr) cnt <= '0;
    else if (bit_end) cnt <= '0;
    else              cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/fifo_uart_tx.sv
// Pops bytes from a sync_fifo and serialises them as UART frames on tx (FIFO_UART_PARITY_EN adds even parity).
// First start bit 3 cycles after a non-empty FIFO is seen in IDLE; frame = (2+DATA_W[+1])*CLKS_PER_BIT cycles.
// One pop per frame; the FIFO buffers while a frame is on the wire; tx_enable low parks the block in IDLE.
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_W       = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           tx_enable,
  fifo_uart_tx_if.master fifo,
  output logic           tx,
  output logic           busy,
  output logic           byte_done
);
  localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_W - 1);
  localparam logic [CW-1:0] PRE_LAST = CW'(CLKS_PER_BIT - 2);

  tx_state_t         state, state_nxt;
  logic [DATA_W-1:0] shift_reg, shift_nxt;
  logic [IW-1:0]     bit_idx, idx_nxt;
  logic              tx_nxt;
  logic              rd_q, rd_nxt;
  logic              byte_done_nxt;
  logic              bit_end;
  logic [CW-1:0]     bit_cnt;
  logic              timer_clr;

  assign fifo.fifo_rd_en = rd_q;

  // The bit timer only runs while a bit is on the line.
  assign timer_clr = (state == IDLE) || (state == REQ) || (state == LOAD);

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk    (clk),
    .reset  (reset),
    .clr    (timer_clr),
    .bit_end(bit_end),
    .cnt    (bit_cnt)
  );

  // State, shifter and every output are registered from the next-state logic.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      tx        <= TX_IDLE_LVL;
      rd_q      <= 1'b0;
      busy      <= 1'b0;
      byte_done <= 1'b0;
      shift_reg <= '0;
      bit_idx   <= '0;
    end else begin
      state     <= state_nxt;
      tx        <= tx_nxt;
      rd_q      <= rd_nxt;
      busy      <= (state_nxt != IDLE);
      byte_done <= byte_done_nxt;
      shift_reg <= shift_nxt;
      bit_idx   <= idx_nxt;
    end
  end

  // Next state and next output values; the shifter rotates so the byte is intact for parity.
  always_comb begin
    state_nxt     = state;
    tx_nxt        = tx;
    rd_nxt        = 1'b0;
    byte_done_nxt = 1'b0;
    shift_nxt     = shift_reg;
    idx_nxt       = bit_idx;
    case (state)
      IDLE: begin
        tx_nxt  = TX_IDLE_LVL;
        idx_nxt = '0;
        if (tx_enable && !fifo.fifo_empty) begin
          state_nxt = REQ;
          rd_nxt    = 1'b1;
        end
      end
      REQ: begin
        state_nxt = LOAD;
      end
      LOAD: begin
        shift_nxt = fifo.fifo_data;
        tx_nxt    = 1'b0;
        state_nxt = START;
      end
      START: begin
        if (bit_end) begin
          state_nxt = DATA;
          tx_nxt    = shift_reg[0];
          idx_nxt   = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_nxt = {shift_reg[0], shift_reg[DATA_W-1:1]};
          if (bit_idx == LAST_IDX) begin
`ifdef FIFO_UART_PARITY_EN
            state_nxt = PARITY;
            tx_nxt    = calc_parity(32'(shift_reg));
`else
            state_nxt = STOP;
            tx_nxt    = 1'b1;
`endif
          end else begin
            idx_nxt = bit_idx + 1'b1;
            tx_nxt  = shift_reg[1];
          end
        end
      end
`ifdef FIFO_UART_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_nxt = STOP;
          tx_nxt    = 1'b1;
        end
      end
`endif
      STOP: begin
        byte_done_nxt = (bit_cnt == PRE_LAST);
        if (bit_end) begin
          state_nxt = IDLE;
          tx_nxt    = TX_IDLE_LVL;
        end
      end
      default: begin
        state_nxt = IDLE;
        tx_nxt    = TX_IDLE_LVL;
      end
    endcase
  end
endmodule
